// File: rtl/projeto_processador_if.sv
// Start/finish handshake between the processor core and whatever drives it.
// Handshake: run is sampled only while the core is idle (T0); the edge that sees run=1
// latches ROM[Din] and starts execution. done is high for exactly the last step of that
// instruction and low in T0. Holding run high past done starts the next instruction at once.
interface projeto_processador_if;
   logic [4:0] Din;
   logic       run;
   logic       done;
   logic [1:0] dbg_step;

   modport master (output Din, output run, input done, input dbg_step);
   modport slave  (input Din, input run, output done, output dbg_step);
endinterface

// File: rtl/projeto_processador.sv
// Multi-cycle 16-bit core: eight registers, 32x16 instruction ROM, 32x16 data RAM.
// Each run request executes one ROM instruction over 2-4 steps (T0..T3).
module projeto_processador (
   input logic                  clock,
   input logic                  reset,
   projeto_processador_if.slave bus
);
   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;
   typedef enum logic [2:0] {SEL_OPND, SEL_MVT, SEL_RX, SEL_RY, SEL_G, SEL_MEM} bus_sel_t;

   localparam logic [2:0] OP_MV  = 3'd0;
   localparam logic [2:0] OP_MVT = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_LD  = 3'd4;
   localparam logic [2:0] OP_ST  = 3'd5;
   localparam logic [2:0] OP_AND = 3'd6;

   step_t       Tstep_Q, tstep_d;
   bus_sel_t    bus_sel;
   logic [15:0] saidaIR, RA_out, saidaALU, BusWires, reg_g;
   logic [4:0]  reg_addr;
   logic [15:0] regs [0:7];
   logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
   // Power-on contents only; reset deliberately leaves data memory untouched.
   logic [15:0] ram [0:31] = '{4: 16'h0007, default: 16'h0000};
   logic [15:0] ram_q;

   logic        done_c, ir_ld, rx_we, a_ld, g_ld, addr_ld, ram_we, ram_re;
   logic [2:0]  op, rx, ry;
   logic [15:0] operand;

   assign op      = saidaIR[15:13];
   assign rx      = saidaIR[11:9];
   assign ry      = saidaIR[2:0];
   assign operand = saidaIR[12] ? {7'd0, saidaIR[8:0]} : regs[ry];

   assign r0 = regs[0];
   assign r1 = regs[1];
   assign r2 = regs[2];
   assign r3 = regs[3];
   assign r4 = regs[4];
   assign r5 = regs[5];
   assign r6 = regs[6];
   assign r7 = regs[7];

   function automatic logic [15:0] rom_word(input logic [4:0] a);
      case (a)
         5'd0:    return 16'h1004;
         5'd1:    return 16'h8200;
         5'd2:    return 16'h5209;
         5'd3:    return 16'hA001;
         5'd4:    return 16'h8401;
         5'd5:    return 16'h1402;
         5'd6:    return 16'hD401;
         5'd7:    return 16'hE003;
         default: return 16'h0000;
      endcase
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) Tstep_Q <= T0;
      else       Tstep_Q <= tstep_d;
   end

   always_comb begin
      tstep_d = Tstep_Q;
      bus_sel = SEL_OPND;
      done_c  = 1'b0;
      ir_ld   = 1'b0;
      rx_we   = 1'b0;
      a_ld    = 1'b0;
      g_ld    = 1'b0;
      addr_ld = 1'b0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      case (Tstep_Q)
         T0: begin
            if (bus.run) begin
               ir_ld   = 1'b1;
               tstep_d = T1;
            end
         end
         T1: begin
            case (op)
               OP_MV:  begin bus_sel = SEL_OPND; rx_we = 1'b1; done_c = 1'b1; tstep_d = T0; end
               OP_MVT: begin bus_sel = SEL_MVT;  rx_we = 1'b1; done_c = 1'b1; tstep_d = T0; end
               OP_ADD, OP_SUB, OP_AND: begin
                  bus_sel = SEL_RX;
                  a_ld    = 1'b1;
                  tstep_d = T2;
               end
               OP_LD, OP_ST: begin
                  bus_sel = SEL_RY;
                  addr_ld = 1'b1;
                  tstep_d = T2;
               end
               default: begin done_c = 1'b1; tstep_d = T0; end
            endcase
         end
         T2: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND: begin g_ld = 1'b1; tstep_d = T3; end
               OP_LD: begin ram_re = 1'b1; tstep_d = T3; end
               OP_ST: begin
                  bus_sel = SEL_RX;
                  ram_we  = 1'b1;
                  done_c  = 1'b1;
                  tstep_d = T0;
               end
               default: tstep_d = T0;
            endcase
         end
         T3: begin
            bus_sel = (op == OP_LD) ? SEL_MEM : SEL_G;
            rx_we   = 1'b1;
            done_c  = 1'b1;
            tstep_d = T0;
         end
         default: tstep_d = T0;
      endcase
   end

   always_comb begin
      case (bus_sel)
         SEL_OPND: BusWires = operand;
         SEL_MVT:  BusWires = {saidaIR[7:0], 8'h00};
         SEL_RX:   BusWires = regs[rx];
         SEL_RY:   BusWires = regs[ry];
         SEL_G:    BusWires = reg_g;
         SEL_MEM:  BusWires = ram_q;
         default:  BusWires = 16'h0000;
      endcase
   end

   always_comb begin
      case (op)
         OP_ADD:  saidaALU = RA_out + operand;
         OP_SUB:  saidaALU = RA_out - operand;
         OP_AND:  saidaALU = RA_out & operand;
         default: saidaALU = 16'h0000;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         saidaIR  <= 16'h0000;
         RA_out   <= 16'h0000;
         reg_g    <= 16'h0000;
         reg_addr <= 5'd0;
         for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      end else begin
         if (ir_ld)   saidaIR  <= rom_word(bus.Din);
         if (a_ld)    RA_out   <= BusWires;
         if (g_ld)    reg_g    <= saidaALU;
         if (addr_ld) reg_addr <= BusWires[4:0];
         if (rx_we)   regs[rx] <= BusWires;
      end
   end

   // Synchronous RAM port; the step counter is forced to T0 by reset, so no write survives it.
   always_ff @(posedge clock) begin
      if (ram_we && !reset) ram[reg_addr] <= BusWires;
      if (ram_re)           ram_q <= ram[reg_addr];
   end

   assign bus.done     = done_c;
   assign bus.dbg_step = Tstep_Q;
endmodule

// File: tb/tb_projeto_processador.sv
// Self-checking bench: directed program walk, then random ROM addresses against an
// instruction-level reference model (register file, RAM array, latency table).
module tb_projeto_processador;
  logic clock = 1'b0;
  logic reset;

  projeto_processador_if bus();

  projeto_processador dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  logic [15:0] m_r   [8];
  logic [15:0] m_ram [32];
  logic [15:0] m_ir;
  logic [15:0] rom_tab [8] = '{16'h1004, 16'h8200, 16'h5209, 16'hA001,
                               16'h8401, 16'h1402, 16'hD401, 16'hE003};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_reg(input int i);
    case (i)
      0: return dut.r0;
      1: return dut.r1;
      2: return dut.r2;
      3: return dut.r3;
      4: return dut.r4;
      5: return dut.r5;
      6: return dut.r6;
      default: return dut.r7;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_ir = 16'h0000;
  endtask

  // Architectural effect of one instruction plus its done latency.
  task automatic model_exec(input logic [4:0] a, output int lat, output logic [15:0] a_exp,
                            output bit has_a, output int st_addr);
    logic [15:0] ir, opnd;
    int x, y, mem;
    ir = (a < 8) ? rom_tab[a] : 16'h0000;
    m_ir = ir;
    x = int'(ir[11:9]);
    y = int'(ir[2:0]);
    opnd = ir[12] ? {7'd0, ir[8:0]} : m_r[y];
    mem = int'(m_r[y]) % 32;
    a_exp = m_r[x];
    has_a = 1'b0;
    st_addr = -1;
    case (ir[15:13])
      3'd0: begin m_r[x] = opnd; lat = 1; end
      3'd1: begin m_r[x] = {ir[7:0], 8'h00}; lat = 1; end
      3'd2: begin m_r[x] = m_r[x] + opnd; lat = 3; has_a = 1'b1; end
      3'd3: begin m_r[x] = m_r[x] - opnd; lat = 3; has_a = 1'b1; end
      3'd4: begin m_r[x] = m_ram[mem]; lat = 3; end
      3'd5: begin m_ram[mem] = m_r[x]; lat = 2; st_addr = mem; end
      3'd6: begin m_r[x] = m_r[x] & opnd; lat = 3; has_a = 1'b1; end
      default: lat = 1;
    endcase
  endtask

  task automatic run_instr(input logic [4:0] a, input bit toggle);
    int lat, n, st_addr;
    logic [15:0] a_exp;
    bit has_a, got;
    @(negedge clock);
    check("idle_step", 16'(dut.Tstep_Q), 16'h0000);
    check("idle_done", 16'(bus.done), 16'h0000);
    bus.Din = a;
    bus.run = 1'b1;
    model_exec(a, lat, a_exp, has_a, st_addr);
    for (int i = 0; i < 8; i++) exp_q.push_back(m_r[i]);
    exp_q.push_back(m_ir);
    @(posedge clock);
    #1;
    bus.run = toggle;
    bus.Din = 5'($urandom_range(0, 31));
    n = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      @(negedge clock);
      n++;
      if (has_a && n == 2) check("ra_t2", dut.RA_out, a_exp);
      if (bus.done) got = 1'b1;
      if (got) bus.run = 1'b0;
      else if (toggle) bus.run = 1'($urandom_range(0, 1));
    end
    check("done_seen", 16'(got), 16'h0001);
    check("latency", 16'(n), 16'(lat));
    @(negedge clock);
    for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), dut_reg(i), exp_q.pop_front());
    check("ir", dut.saidaIR, exp_q.pop_front());
    if (st_addr >= 0) check($sformatf("ram%0d", st_addr), dut.ram[st_addr], m_ram[st_addr]);
  endtask

  task automatic mid_reset(input logic [4:0] a);
    @(negedge clock);
    bus.Din = a;
    bus.run = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clock);
      check("rst_step", 16'(dut.Tstep_Q), 16'h0000);
      check("rst_done", 16'(bus.done), 16'h0000);
    end
    reset = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), dut_reg(i), m_r[i]);
    check("rst_ir", dut.saidaIR, m_ir);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_ram[i] = (i == 4) ? 16'h0007 : 16'h0000;
    model_reset();
    reset = 1'b1;
    bus.run = 1'b1;
    bus.Din = 5'd0;
    repeat (5) begin
      @(negedge clock);
      check("reset_step", 16'(dut.Tstep_Q), 16'h0000);
      check("reset_done", 16'(bus.done), 16'h0000);
      for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), dut_reg(i), 16'h0000);
    end
    reset = 1'b0;
    bus.run = 1'b0;

    run_instr(5'd0, 1'b0);
    check("plan_r0", dut.r0, 16'h0004);
    check("plan_ir0", dut.saidaIR, 16'h1004);
    run_instr(5'd1, 1'b0);
    check("plan_ld_r1", dut.r1, 16'h0007);
    run_instr(5'd2, 1'b0);
    check("plan_add_r1", dut.r1, 16'h0010);
    run_instr(5'd3, 1'b0);
    check("plan_st_ram16", dut.ram[16], 16'h0004);
    run_instr(5'd4, 1'b0);
    check("plan_ld_r2", dut.r2, 16'h0004);
    run_instr(5'd5, 1'b0);
    check("plan_mv_r2", dut.r2, 16'h0002);
    run_instr(5'd6, 1'b1);
    check("plan_and_r2", dut.r2, 16'h0000);
    run_instr(5'd7, 1'b0);

    for (int k = 0; k < 120; k++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      if (k % 25 == 12) mid_reset(a);
      else run_instr(a, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 32; i++) check($sformatf("final_ram%0d", i), dut.ram[i], m_ram[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/projeto_processador.md
# projeto_processador

Single-clock, multi-cycle 16-bit processor core with eight general registers, an internal 32×16 instruction ROM and an internal 32×16 data RAM.
- Each `run` request fetches the instruction at ROM address `Din`, executes it over 2–4 cycles and pulses `done`.
- It is the top of the processor project; testbenches drive the ports and probe the internal state listed below.

## Interface
- No parameters.
- `clock`  in  1  — single system clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `Din`  in  5  — instruction ROM address to fetch on the next start.
- `run`  in  1  — start request, sampled only in step T0.
- `done`  out  1  — combinational; high during the final step of an instruction.

Internal state, hierarchically visible for verification:
- `r0`–`r7` (16 b each)
- `Tstep_Q` (2 b step counter)
- `saidaIR` (16 b instruction register)
- `RA_out` (16 b A register)
- `saidaALU` (16 b)
- `BusWires` (16 b)

## Operation
**Instruction format:** `[15:13]` opcode, `[12]` I (immediate flag), `[11:9]` rX, `[8:0]` operand.
- Operand with I=1: 9-bit immediate, zero-extended to 16 b.
- Operand with I=0: register rY = `[2:0]`.

**Opcodes:**
- 000 mv: rX ← op
- 001 mvt: rX ← {`[7:0]`, 8'h00}
- 010 add: rX ← rX+op
- 011 sub: rX ← rX−op
- 100 ld: rX ← RAM[rY]
- 101 st: RAM[rY] ← rX
- 110 and: rX ← rX & op
- 111: reserved no-op

**Arithmetic and addressing:**
- All arithmetic is 16-bit modulo; carry and borrow are discarded.
- RAM is addressed by the low 5 bits of rY, so addresses wrap modulo 32.

**Fixed ROM contents:**
- 0: 0x1004
- 1: 0x8200
- 2: 0x5209
- 3: 0xA001
- 4: 0x8401
- 5: 0x1402
- 6: 0xD401
- 7: 0xE003
- All other addresses: 0x0000

**RAM:** initial contents 0, except RAM[4] = 0x0007. RAM is not cleared by reset.

**Step FSM (`Tstep_Q`):**
- **T0 idle.** If `run`=1: IR ← ROM[`Din`], go to T1. Otherwise stay.
- **T1.**
  - mv, mvt: write rX, `done`=1, go to T0.
  - 111: `done`=1, go to T0, no state change.
  - add, sub, and: A ← rX, go to T2.
  - ld, st: address register ← rY, go to T2.
- **T2.**
  - add, sub, and: G ← A op operand, go to T3.
  - ld: RAM read issued (synchronous), go to T3.
  - st: RAM write of rX, `done`=1, go to T0.
- **T3.**
  - add, sub, and: rX ← G, `done`=1, go to T0.
  - ld: rX ← RAM data, `done`=1, go to T0.

## Timing
**Latency from the T0 edge that samples `run`=1 to `done` high:**
- mv, mvt, 111: 1 cycle
- st: 2 cycles
- add, sub, and, ld: 3 cycles

**`done` and `run` handshake:**
- `done` is high only during the final step and is low in T0.
- `run` is ignored outside T0; toggling it mid-instruction has no effect.
- If `run` is still high in T0 after `done`, the next instruction (at the current `Din`) starts on the next edge with no idle cycle.

**Other timing rules:**
- `Din` is sampled only on the starting edge and may change afterwards.
- Reset state:
  - `Tstep_Q`=T0, `done`=0.
  - IR, A, G, address register and r0–r7 all = 0x0000.
- Reset asserted mid-instruction aborts it immediately. No register or RAM write from the aborted step occurs after reset asserts.
- While `reset` is held high the core stays in T0 with `done`=0, regardless of `run`.

## Test plan
- **Reset.** Assert `reset` with `run`=1 for 5 cycles → `Tstep_Q`=0, `done`=0, r0–r7=0 throughout.
- **mv immediate.** Release reset; `Din`=0, pulse `run` → after 1 cycle `done`=1, r0=0x0004, IR=0x1004.
- **ld.** Then `Din`=1, `run` → r1=0x0007 after 3 cycles.
- **add immediate.** Then `Din`=2 → r1=0x0010, with `RA_out`=0x0007 during T2.
- **st then ld.** `Din`=3 (st r0,[r1]) → RAM[16]=0x0004, `done` after 2 cycles. Then `Din`=4 → r2=0x0004.
- **Ignored `run` and and-immediate.**
  - `Din`=5 → r2=0x0002.
  - `Din`=6 with `run` toggled mid-instruction → execution unaffected, r2=0x0000.
  - Reserved `Din`=7 → `done` after 1 cycle, no register changes.
